// File: rtl/issue_arbiter.sv
// issue_arbiter: round-robin issue-slot scheduler.
// Each cycle it picks one ready requester (reservation-station bank) and
// latches that bank's operand tags and ROB index into the issue register.
// The issue register drives the regfile read indices and the EX stage.
//
// Handshake (valid/ready): a requester offers an entry by holding req_valid[i]
// high with stable contents; the entry is consumed only at an edge where
// grant[i] is 1. Downstream consumes the issue register at an edge where
// is_valid && ex_ready, and the register is refilled at that same edge.
// Squash drops the issue register and blocks any grant in that cycle.
module issue_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int PREG_IDX_W = 6,
    parameter int ROB_IDX_W  = 5,
    parameter int REQ_ID_W   = $clog2(NUM_REQ)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*PREG_IDX_W-1:0] req_rs1_idx,
    input  logic [NUM_REQ*PREG_IDX_W-1:0] req_rs2_idx,
    input  logic [NUM_REQ*ROB_IDX_W-1:0]  req_rob_index,
    input  logic                          ex_ready,
    input  logic                          squash,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          is_valid,
    output logic [REQ_ID_W-1:0]           is_req_id,
    output logic [PREG_IDX_W-1:0]         rs1_preg_idx,
    output logic [PREG_IDX_W-1:0]         rs2_preg_idx,
    output logic [ROB_IDX_W-1:0]          is_rob_index
);

    // Round-robin pointer: the requester with highest priority this cycle.
    logic [REQ_ID_W-1:0]   rr_ptr;

    logic [REQ_ID_W-1:0]   winner;
    logic                  any;
    logic                  adv;
    logic [PREG_IDX_W-1:0] sel_rs1;
    logic [PREG_IDX_W-1:0] sel_rs2;
    logic [ROB_IDX_W-1:0]  sel_rob;

    // The issue register can take a new entry when it is empty or being drained.
    assign adv = !squash && (!is_valid || ex_ready);
    assign any = |req_valid;

    // Pick the first valid requester scanning upward from rr_ptr with wrap.
    // NUM_REQ is a power of two, so the pointer addition wraps naturally.
    always_comb begin
        logic                found;
        logic [REQ_ID_W-1:0] idx;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = rr_ptr + REQ_ID_W'(k);
            if (!found && req_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Mux the winner's payload out of the packed request buses.
    always_comb begin
        sel_rs1 = '0;
        sel_rs2 = '0;
        sel_rob = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == REQ_ID_W'(i)) begin
                sel_rs1 = req_rs1_idx[i*PREG_IDX_W +: PREG_IDX_W];
                sel_rs2 = req_rs2_idx[i*PREG_IDX_W +: PREG_IDX_W];
                sel_rob = req_rob_index[i*ROB_IDX_W +: ROB_IDX_W];
            end
        end
    end

    // One-hot grant; suppressed in reset, squash, stall and when nobody is ready.
    always_comb begin
        grant = '0;
        if (!reset && adv && any) begin
            grant = NUM_REQ'(1) << winner;
        end
    end

    // Issue register and round-robin pointer update.
    always_ff @(posedge clock) begin
        if (reset) begin
            is_valid     <= 1'b0;
            is_req_id    <= '0;
            rs1_preg_idx <= '0;
            rs2_preg_idx <= '0;
            is_rob_index <= '0;
            rr_ptr       <= '0;
        end else if (squash) begin
            // Flush drops the held instruction; rotation position is kept.
            is_valid <= 1'b0;
        end else if (adv) begin
            is_valid <= any;
            if (any) begin
                is_req_id    <= winner;
                rs1_preg_idx <= sel_rs1;
                rs2_preg_idx <= sel_rs2;
                is_rob_index <= sel_rob;
                rr_ptr       <= winner + REQ_ID_W'(1);
            end
        end
    end

endmodule
